// File: rtl/partial_sum_serializer_if.sv
// rtl/partial_sum_serializer_if.sv - column wave in, serialized partial-sum stream out
interface partial_sum_serializer_if #(
  parameter int NUM_COLS = 16,
  parameter int AW       = 28,
  parameter int DW       = 16
);
  logic [NUM_COLS*AW-1:0] col_data_flat;
  logic [NUM_COLS-1:0]    col_valid;
  logic                   in_ready;
  logic                   clear;
  logic [DW-1:0]          partial_out;
  logic [3:0]             col_id;
  logic                   partial_valid;
  logic                   wave_done;
  logic                   overflow;
  logic                   sat_hit;

  modport master (
    output col_data_flat, col_valid, clear,
    input  in_ready, partial_out, col_id, partial_valid, wave_done, overflow, sat_hit
  );

  modport slave (
    input  col_data_flat, col_valid, clear,
    output in_ready, partial_out, col_id, partial_valid, wave_done, overflow, sat_hit
  );
endinterface

// File: rtl/partial_sum_serializer.sv
// rtl/partial_sum_serializer.sv - captures a wave of column sums, emits them rescaled in column order
// Optional saturating narrow selected by PARTIAL_SAT_EN (default: wrap).
module partial_sum_serializer #(
  parameter int NUM_COLS = 16,
  parameter int AW       = 28,
  parameter int DW       = 16,
  parameter int SHIFT    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  partial_sum_serializer_if.slave  bus
);
  logic [NUM_COLS-1:0]   pending_q, pending_d;
  logic signed [AW-1:0]  hold_q [NUM_COLS];
  logic signed [AW-1:0]  hold_d [NUM_COLS];
  logic [DW-1:0]         partial_out_q, partial_out_d;
  logic [3:0]            col_id_q, col_id_d;
  logic                  partial_valid_q, partial_valid_d;
  logic                  wave_done_q, wave_done_d;
  logic                  overflow_q, overflow_d;
  logic                  sat_hit_q, sat_hit_d;

  logic                  in_ready;
  logic                  wave_in;
  logic [NUM_COLS-1:0]   sel_onehot;
  logic [3:0]            sel_idx;
  logic signed [AW-1:0]  sel_t;
  logic [DW-1:0]         narrow_val;
  logic                  narrow_sat;

  assign in_ready   = (pending_q == '0);
  assign wave_in    = (bus.col_valid != '0);
  assign sel_onehot = pending_q & (~pending_q + NUM_COLS'(1));

  always_comb begin
    sel_idx = 4'd0;
    for (int c = NUM_COLS - 1; c >= 0; c--) begin
      if (pending_q[c]) sel_idx = 4'(c);
    end
  end

  assign sel_t = hold_q[sel_idx] >>> SHIFT;

`ifdef PARTIAL_SAT_EN
  // Fits in DW bits only when every bit above the DW sign bit matches the sign.
  logic t_fits;
  assign t_fits     = (sel_t[AW-1:DW-1] == {(AW-DW+1){sel_t[AW-1]}});
  assign narrow_val = t_fits ? sel_t[DW-1:0]
                    : (sel_t[AW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}});
  assign narrow_sat = !t_fits;
`else
  logic unused_t_hi;
  assign unused_t_hi = ^sel_t[AW-1:DW];
  assign narrow_val  = sel_t[DW-1:0];
  assign narrow_sat  = 1'b0;
`endif

  always_comb begin
    pending_d       = pending_q;
    hold_d          = hold_q;
    partial_out_d   = partial_out_q;
    col_id_d        = col_id_q;
    partial_valid_d = 1'b0;
    wave_done_d     = 1'b0;
    overflow_d      = overflow_q;
    sat_hit_d       = sat_hit_q;
    if (bus.clear) begin
      pending_d  = '0;
      overflow_d = 1'b0;
      sat_hit_d  = 1'b0;
    end else begin
      if (!in_ready) begin
        pending_d       = pending_q & ~sel_onehot;
        partial_out_d   = narrow_val;
        col_id_d        = sel_idx;
        partial_valid_d = 1'b1;
        wave_done_d     = (pending_q == sel_onehot);
        if (narrow_sat) sat_hit_d = 1'b1;
      end
      // A capture can only coincide with an idle pending vector, so it never races the emit.
      if (wave_in) begin
        if (in_ready) begin
          pending_d = bus.col_valid;
          for (int c = 0; c < NUM_COLS; c++) begin
            if (bus.col_valid[c]) hold_d[c] = bus.col_data_flat[c*AW +: AW];
          end
        end else begin
          overflow_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q       <= '0;
      hold_q          <= '{default: '0};
      partial_out_q   <= '0;
      col_id_q        <= 4'd0;
      partial_valid_q <= 1'b0;
      wave_done_q     <= 1'b0;
      overflow_q      <= 1'b0;
      sat_hit_q       <= 1'b0;
    end else begin
      pending_q       <= pending_d;
      hold_q          <= hold_d;
      partial_out_q   <= partial_out_d;
      col_id_q        <= col_id_d;
      partial_valid_q <= partial_valid_d;
      wave_done_q     <= wave_done_d;
      overflow_q      <= overflow_d;
      sat_hit_q       <= sat_hit_d;
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.partial_out   = partial_out_q;
  assign bus.col_id        = col_id_q;
  assign bus.partial_valid = partial_valid_q;
  assign bus.wave_done     = wave_done_q;
  assign bus.overflow      = overflow_q;
  assign bus.sat_hit       = sat_hit_q;
endmodule

// File: tb/tb_partial_sum_serializer.sv
// tb/tb_partial_sum_serializer.sv - directed and randomized checks against a queue-based reference model
module tb_partial_sum_serializer;
  localparam int NUM_COLS = 16;
  localparam int AW       = 28;
  localparam int DW       = 16;
  localparam int SHIFT    = 8;
  localparam longint MAXV = (longint'(1) <<< (DW - 1)) - 1;
  localparam longint MINV = -MAXV - 1;

  typedef struct {
    logic [DW-1:0] val;
    logic [3:0]    col;
    bit            sat;
  } elem_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;

  elem_t         exp_q[$];
  logic [DW-1:0] m_out;
  logic [3:0]    m_col;
  bit            m_valid, m_done, m_ovf, m_sat;

  partial_sum_serializer_if #(.NUM_COLS(NUM_COLS), .AW(AW), .DW(DW)) bus ();

  partial_sum_serializer #(.NUM_COLS(NUM_COLS), .AW(AW), .DW(DW), .SHIFT(SHIFT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW:0] ref_narrow(input logic [AW-1:0] x);
    longint s, t;
    s = longint'($signed(x));
    t = s >>> SHIFT;
`ifdef PARTIAL_SAT_EN
    if (t > MAXV) return {1'b1, DW'(MAXV)};
    if (t < MINV) return {1'b1, DW'(MINV)};
`endif
    return {1'b0, DW'(t)};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_out = '0; m_col = '0; m_valid = 0; m_done = 0; m_ovf = 0; m_sat = 0;
  endtask

  task automatic model_edge();
    bit    idle;
    elem_t e;
    logic [DW:0] n;
    if (bus.clear) begin
      exp_q.delete();
      m_valid = 0; m_done = 0; m_ovf = 0; m_sat = 0;
      return;
    end
    idle = (exp_q.size() == 0);
    m_valid = 0;
    m_done  = 0;
    if (!idle) begin
      e = exp_q.pop_front();
      m_out = e.val; m_col = e.col; m_valid = 1;
      m_done = (exp_q.size() == 0);
      if (e.sat) m_sat = 1;
    end
    if (bus.col_valid != 0) begin
      if (idle) begin
        for (int c = 0; c < NUM_COLS; c++) begin
          if (bus.col_valid[c]) begin
            n = ref_narrow(bus.col_data_flat[c*AW +: AW]);
            e.val = n[DW-1:0]; e.col = 4'(c); e.sat = n[DW];
            exp_q.push_back(e);
          end
        end
      end else begin
        m_ovf = 1;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".in_ready"},      32'(bus.in_ready),      32'(exp_q.size() == 0));
    check({tag, ".partial_valid"}, 32'(bus.partial_valid), 32'(m_valid));
    check({tag, ".wave_done"},     32'(bus.wave_done),     32'(m_done));
    check({tag, ".partial_out"},   32'(bus.partial_out),   32'(m_out));
    check({tag, ".col_id"},        32'(bus.col_id),        32'(m_col));
    check({tag, ".overflow"},      32'(bus.overflow),      32'(m_ovf));
    check({tag, ".sat_hit"},       32'(bus.sat_hit),       32'(m_sat));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    compare_all(tag);
  endtask

  task automatic idle_inputs();
    bus.col_valid = '0;
    bus.clear = 1'b0;
  endtask

  task automatic set_col(input int c, input logic [AW-1:0] v);
    bus.col_data_flat[c*AW +: AW] = v;
  endtask

  task automatic drain(input string tag);
    idle_inputs();
    for (int i = 0; i < NUM_COLS + 2; i++) step(tag);
  endtask

  initial begin
    logic [31:0] r;
    bus.col_data_flat = '0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    #2 rst_n = 1'b1;

    // Single column: hold = 0x300 -> 3 on col 2
    set_col(2, 28'h0000300);
    bus.col_valid = 16'h0004;
    step("single_cap");
    check("single.in_ready_low", 32'(bus.in_ready), 32'd0);
    idle_inputs();
    step("single_out");
    check("single.partial_out", 32'(bus.partial_out), 32'd3);
    check("single.col_id", 32'(bus.col_id), 32'd2);
    check("single.done", 32'(bus.wave_done), 32'd1);
    check("single.in_ready_high", 32'(bus.in_ready), 32'd1);

    // Full wave: column c = (c+1)<<8
    for (int c = 0; c < NUM_COLS; c++) set_col(c, AW'((c + 1) << 8));
    bus.col_valid = 16'hFFFF;
    step("full_cap");
    idle_inputs();
    for (int c = 0; c < NUM_COLS; c++) begin
      step("full_out");
      check("full.valid", 32'(bus.partial_valid), 32'd1);
      check("full.value", 32'(bus.partial_out), 32'(c + 1));
      check("full.col", 32'(bus.col_id), 32'(c));
      check("full.done", 32'(bus.wave_done), 32'(c == NUM_COLS - 1));
    end
    drain("full_drain");

    // Negative value keeps its sign through the shift
    set_col(5, 28'hFFFFE80);
    bus.col_valid = 16'h0020;
    step("neg_cap");
    idle_inputs();
    step("neg_out");
    check("neg.partial_out", 32'(bus.partial_out), 32'h0000FFFE);
    check("neg.col_id", 32'(bus.col_id), 32'd5);
    drain("neg_drain");

    // Busy drop followed by clear
    for (int c = 0; c < 4; c++) set_col(c, AW'((c + 10) << 8));
    bus.col_valid = 16'h000F;
    step("drop_cap");
    set_col(0, 28'h0007700);
    bus.col_valid = 16'h0003;
    step("drop_busy");
    idle_inputs();
    step("drop_after");
    check("drop.overflow", 32'(bus.overflow), 32'd1);
    check("drop.first_wave_out", 32'(bus.partial_out), 32'd11);
    bus.clear = 1'b1;
    step("clear");
    bus.clear = 1'b0;
    check("clear.overflow", 32'(bus.overflow), 32'd0);
    check("clear.valid", 32'(bus.partial_valid), 32'd0);
    check("clear.in_ready", 32'(bus.in_ready), 32'd1);
    drain("clear_drain");

    // Narrowing of a value too wide for DW bits
    set_col(0, 28'h1000000);
    bus.col_valid = 16'h0001;
    step("narrow_cap");
    idle_inputs();
    step("narrow_out");
`ifdef PARTIAL_SAT_EN
    check("narrow.sat_out", 32'(bus.partial_out), 32'h00007FFF);
    check("narrow.sat_hit", 32'(bus.sat_hit), 32'd1);
`else
    check("narrow.wrap_out", 32'(bus.partial_out), 32'h00000000);
    check("narrow.sat_hit", 32'(bus.sat_hit), 32'd0);
`endif
    bus.clear = 1'b1;
    step("narrow_clear");
    drain("narrow_drain");

    // Reset mid-wave after 3 of 8 elements
    for (int c = 0; c < 8; c++) set_col(c, AW'((c + 1) << 9));
    bus.col_valid = 16'h00FF;
    step("rst_cap");
    idle_inputs();
    for (int i = 0; i < 3; i++) step("rst_emit");
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all("rst_mid");
    check("rst_mid.in_ready", 32'(bus.in_ready), 32'd1);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) step("rst_after");

    // Randomized traffic against the reference model
    for (int i = 0; i < 1500; i++) begin
      bus.clear = ($urandom_range(0, 99) < 3);
      bus.col_valid = ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'h0;
      for (int c = 0; c < NUM_COLS; c++) begin
        r = $urandom;
        if ($urandom_range(0, 3) == 0) set_col(c, r[AW-1:0]);
        else set_col(c, {{(AW-20){r[19]}}, r[19:0]});
      end
      step("rand");
    end
    drain("final_drain");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
